// File: rtl/esc_sequencer_if.sv
// esc_sequencer port bundle.
// Control side (start/range/abort/ack) and write-side outputs.
interface esc_sequencer_if #(
    parameter int NUM_CH = 27
);
    logic              start;
    logic [4:0]        first;
    logic [4:0]        last;
    logic              abort;
    logic              ack;
    logic [NUM_CH-1:0] sel;
    logic [7:0]        addr;
    logic              req;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, first, last, abort, ack,
        input  sel, addr, req, busy, done, err
    );

    modport slave (
        input  start, first, last, abort, ack,
        output sel, addr, req, busy, done, err
    );
endinterface

// File: rtl/esc_sequencer.sv
// Write-sweep sequencer for the RTC register-write datapath.
// Walks channels first..last, one acked request per channel.
module esc_sequencer #(
    parameter int          NUM_CH    = 27,
    parameter logic [7:0]  ADDR_BASE = 8'h00,
    parameter int          GAP       = 2,
    parameter int          TIMEOUT   = 255
) (
    input  logic           clk,
    input  logic           reset,
    esc_sequencer_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GLIM = GW'(GAP - 1);
    localparam logic [5:0]    NCH  = 6'(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [4:0]        last_q, last_d;
    logic [GW-1:0]     gcnt_q, gcnt_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              eflag_q, eflag_d;

    logic [NUM_CH-1:0] sel_q, sel_d;
    logic [7:0]        addr_q, addr_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              range_ok;

    assign range_ok = (bus.first <= bus.last) && ({1'b0, bus.last} < NCH);

    // Next-state logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        gcnt_d  = gcnt_q;
        tcnt_d  = tcnt_q;
        eflag_d = eflag_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (range_ok) begin
                        idx_d   = bus.first;
                        last_d  = bus.last;
                        eflag_d = 1'b0;
                        tcnt_d  = '0;
                        state_d = S_REQ;
                    end else begin
                        eflag_d = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            S_REQ: begin
                tcnt_d = tcnt_q + TW'(1);
                if (bus.abort) begin
                    eflag_d = 1'b1;
                    state_d = S_FIN;
                end else if (bus.ack) begin
                    if (idx_q == last_q) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        gcnt_d  = '0;
                        state_d = S_GAP;
                    end
                end else if (tcnt_q == TLIM) begin
                    eflag_d = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_GAP: begin
                if (bus.abort) begin
                    eflag_d = 1'b1;
                    state_d = S_FIN;
                end else if (gcnt_q == GLIM) begin
                    tcnt_d  = '0;
                    state_d = S_REQ;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        sel_d  = '0;
        addr_d = '0;
        req_d  = 1'b0;
        if (state_d == S_REQ) begin
            sel_d  = NUM_CH'(1) << idx_d;
            addr_d = ADDR_BASE + {3'b000, idx_d};
            req_d  = 1'b1;
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
        err_d  = done_d & eflag_d;
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            gcnt_q  <= '0;
            tcnt_q  <= '0;
            eflag_q <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            gcnt_q  <= gcnt_d;
            tcnt_q  <= tcnt_d;
            eflag_q <= eflag_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.sel  = sel_q;
    assign bus.addr = addr_q;
    assign bus.req  = req_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_esc_sequencer.sv
// Bench for esc_sequencer.
// Per-cycle expectation tables built from sweep timing rules.
module tb_esc_sequencer;

    localparam int         NCH  = 27;
    localparam logic [7:0] BASE = 8'h10;
    localparam int         GP   = 2;
    localparam int         TO   = 16;
    localparam int         MAXC = 400;

    typedef struct packed {
        logic       start;
        logic [4:0] first;
        logic [4:0] last;
        logic       abort;
        logic       ack;
    } stim_t;

    typedef struct packed {
        logic [NCH-1:0] sel;
        logic [7:0]     addr;
        logic           req;
        logic           busy;
        logic           done;
        logic           err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    esc_sequencer_if #(.NUM_CH(NCH)) bus ();

    esc_sequencer #(
        .NUM_CH   (NCH),
        .ADDR_BASE(BASE),
        .GAP      (GP),
        .TIMEOUT  (TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    stim_t st  [MAXC];
    exp_t  ex  [MAXC];
    exp_t  cap [MAXC];
    int    len;
    int    cidx;
    bit    chk_on = 1'b0;
    int    nreq;
    logic  req_prev;
    int    n_chk = 0;
    int    n_fail = 0;
    int    fin_c;

    function automatic exp_t dut_out();
        exp_t o;
        o.sel  = bus.sel;
        o.addr = bus.addr;
        o.req  = bus.req;
        o.busy = bus.busy;
        o.done = bus.done;
        o.err  = bus.err;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Compare DUT outputs with the model table every cycle of a run.
    always @(negedge clk) begin
        if (chk_on) begin
            cap[cidx] = dut_out();
            n_chk++;
            if (cap[cidx] !== ex[cidx]) begin
                n_fail++;
                $display("FAIL cyc%0d outputs: got %h expected %h",
                         cidx, cap[cidx], ex[cidx]);
            end
            if (bus.req && !req_prev) nreq++;
            req_prev = bus.req;
        end
    end

    task automatic clear_tables();
        for (int i = 0; i < MAXC; i++) begin
            st[i]  = '0;
            ex[i]  = '0;
            cap[i] = '0;
        end
    endtask

    task automatic put_req(input int c, input int ch);
        ex[c].sel  = NCH'(1) << ch;
        ex[c].addr = BASE + 8'(ch);
        ex[c].req  = 1'b1;
        ex[c].busy = 1'b1;
    endtask

    task automatic put_gap(input int c);
        ex[c].busy = 1'b1;
    endtask

    task automatic put_fin(input int c, input logic e);
        ex[c].busy = 1'b1;
        ex[c].done = 1'b1;
        ex[c].err  = e;
    endtask

    task automatic put_start(input int c, input int f, input int l);
        st[c].start = 1'b1;
        st[c].first = 5'(f);
        st[c].last  = 5'(l);
    endtask

    // Sweep model: each channel holds req for lat+1 cycles, then GP idle cycles.
    task automatic build_sweep(input int f, input int l, input int lat,
                               input int abort_at, input bit noack);
        int t;
        int j;
        clear_tables();
        put_start(0, f, l);
        t = 1;
        j = 0;
        fin_c = 0;
        if (f > l || l >= NCH) begin
            fin_c = 1;
            put_fin(1, 1'b1);
        end else begin
            for (int ch = f; ch <= l; ch++) begin
                if (noack) begin
                    for (int k = 0; k < TO; k++) put_req(t + k, ch);
                    fin_c = t + TO;
                    put_fin(fin_c, 1'b1);
                    break;
                end
                for (int k = 0; k <= lat; k++) put_req(t + k, ch);
                st[t + lat].ack = 1'b1;
                if (j == abort_at) begin
                    st[t + lat].abort = 1'b1;
                    fin_c = t + lat + 1;
                    put_fin(fin_c, 1'b1);
                    break;
                end
                if (ch == l) begin
                    fin_c = t + lat + 1;
                    put_fin(fin_c, 1'b0);
                    break;
                end
                for (int k = 0; k < GP; k++) put_gap(t + lat + 1 + k);
                t += lat + 1 + GP;
                j++;
            end
        end
        len = fin_c + 5;
    endtask

    task automatic drive(input stim_t s);
        bus.start = s.start;
        bus.first = s.first;
        bus.last  = s.last;
        bus.abort = s.abort;
        bus.ack   = s.ack;
    endtask

    task automatic run();
        @(posedge clk);
        #1;
        nreq = 0;
        req_prev = 1'b0;
        for (int c = 0; c < len; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            cidx = c;
            chk_on = 1'b1;
            drive(st[c]);
        end
        @(posedge clk);
        #1;
        chk_on = 1'b0;
        drive('0);
    endtask

    initial begin
        int dcnt;
        drive('0);
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", 64'(dut_out()), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // full sweep, ack in 3rd REQ cycle
        build_sweep(0, 26, 2, -1, 1'b0);
        run();
        check("full nreq", 64'(nreq), 64'd27);
        check("full sel0", 64'(cap[1].sel), 64'h1);
        check("full addr0", 64'(cap[1].addr), 64'h10);
        check("full sel26", 64'(cap[131].sel), 64'h4000000);
        check("full addr26", 64'(cap[131].addr), 64'h2A);
        check("full done", 64'({cap[134].done, cap[134].err}), 64'b10);
        check("full busy end", 64'({cap[134].busy, cap[135].busy}), 64'b10);

        // single channel, zero-wait ack
        build_sweep(5, 5, 0, -1, 1'b0);
        run();
        check("single sel", 64'(cap[1].sel), 64'h20);
        check("single addr", 64'(cap[1].addr), 64'h15);
        check("single done", 64'({cap[2].done, cap[2].err}), 64'b10);
        check("single nreq", 64'(nreq), 64'd1);

        // invalid ranges
        build_sweep(10, 3, 0, -1, 1'b0);
        run();
        check("inv1 done err", 64'({cap[1].done, cap[1].err}), 64'b11);
        check("inv1 nreq", 64'(nreq), 64'd0);
        build_sweep(0, 27, 0, -1, 1'b0);
        run();
        check("inv2 done err", 64'({cap[1].done, cap[1].err}), 64'b11);
        check("inv2 nreq", 64'(nreq), 64'd0);

        // timeout, then a late ack
        build_sweep(3, 4, 0, -1, 1'b1);
        st[fin_c + 2].ack = 1'b1;
        run();
        check("to req16", 64'(cap[16].req), 64'd1);
        check("to fin", 64'({cap[17].req, cap[17].done, cap[17].err}),
              64'b011);
        check("to sel off", 64'(cap[17].sel), 64'd0);
        check("to nreq", 64'(nreq), 64'd1);
        check("to late ack", 64'(cap[20]), 64'd0);

        // abort with 3rd ack, plus ignored starts
        build_sweep(0, 26, 2, 2, 1'b0);
        put_start(4, 20, 21);
        put_start(8, 0, 0);
        run();
        check("abort nreq", 64'(nreq), 64'd3);
        check("abort fin", 64'({cap[14].req, cap[14].done, cap[14].err}),
              64'b011);

        // reset mid-REQ
        @(posedge clk);
        #1;
        drive('{start: 1'b1, first: 5'd2, last: 5'd4, abort: 1'b0, ack: 1'b0});
        @(posedge clk);
        #1;
        drive('0);
        @(posedge clk);
        #1;
        check("pre-rst req", 64'(bus.req), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst async", 64'(dut_out()), 64'd0);
        dcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        check("rst no done", 64'(dcnt), 64'd0);

        build_sweep(7, 7, 0, -1, 1'b0);
        run();
        check("post-rst sel", 64'(cap[1].sel), 64'h80);
        check("post-rst addr", 64'(cap[1].addr), 64'h17);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
